// File: rtl/instr_fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        ERR  = 2'd3
    } fetch_state_e;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction memory req/gnt/rvalid bus between the fetch unit and imem.
interface instr_fetch_unit_if;
    import instr_fetch_unit_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            gnt;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, addr, input gnt, rvalid, rdata);
    modport slave  (input req, addr, output gnt, rvalid, rdata);

endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns PC, OldPC, IR and past-IR; fetches over a
// req/gnt/rvalid bus and flags a bus error when a response never arrives.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned     TIMEOUT_CYCLES = 16
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                IRWrite_i,
    input  logic                PCWrite_i,
    input  logic [XLEN-1:0]     PCNext_i,
    instr_fetch_unit_if.master  imem,
    output logic [XLEN-1:0]     PC_o,
    output logic [XLEN-1:0]     OldPC_o,
    output logic [XLEN-1:0]     Instr_o,
    output logic [XLEN-1:0]     InstrPast_o,
    output logic                busy_o,
    output logic                fetch_err_o,
    output logic                misalign_o
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [XLEN-1:0]  RESET_FETCH_ADDR = {RESET_PC[XLEN-1:2], 2'b00};

    fetch_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  fetch_addr_q, fetch_addr_d;
    logic             rsp_take;

    // State, timeout counter and latched fetch address
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            fetch_addr_q <= RESET_FETCH_ADDR;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            fetch_addr_q <= fetch_addr_d;
        end
    end

    // Next state; the counter only advances below its terminal value, so it cannot wrap
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        fetch_addr_d = fetch_addr_q;
        rsp_take     = 1'b0;
        case (state_q)
            IDLE: begin
                if (IRWrite_i) begin
                    state_d      = REQ;
                    fetch_addr_d = {PC_o[XLEN-1:2], 2'b00};
                end
            end
            REQ: begin
                if (imem.gnt) begin
                    state_d = RESP;
                    cnt_d   = '0;
                end
            end
            RESP: begin
                if (imem.rvalid) begin
                    state_d  = IDLE;
                    rsp_take = 1'b1;
                end else if (cnt_q >= CNT_LAST) begin
                    state_d = ERR;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Status outputs registered from the next state; async reset clears them at once
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            imem.req    <= 1'b0;
            busy_o      <= 1'b0;
            fetch_err_o <= 1'b0;
        end else begin
            imem.req    <= (state_d == REQ);
            busy_o      <= (state_d != IDLE);
            fetch_err_o <= (state_d == ERR);
        end
    end

    assign imem.addr = fetch_addr_q;

    // PC, instruction and past-instruction registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            PC_o        <= RESET_PC;
            OldPC_o     <= RESET_PC;
            Instr_o     <= NOP_INSTR;
            InstrPast_o <= NOP_INSTR;
            misalign_o  <= 1'b0;
        end else begin
            if (PCWrite_i) begin
                PC_o <= PCNext_i;
                if (PCNext_i[1:0] != 2'b00) begin
                    misalign_o <= 1'b1;
                end
            end
            if (rsp_take) begin
                InstrPast_o <= Instr_o;
                Instr_o     <= imem.rdata;
                OldPC_o     <= fetch_addr_q;
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: directed fetches, back-pressure,
// timeout, PC writes, misalignment and reset abort.
module tb_instr_fetch_unit;

    typedef struct {
        logic        err;
        logic [31:0] instr;
        logic [31:0] past;
        logic [31:0] oldpc;
        int          busy;
    } resp_t;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        IRWrite_i = 1'b0;
    logic        PCWrite_i = 1'b0;
    logic [31:0] PCNext_i = 32'h0;
    logic [31:0] PC_o, OldPC_o, Instr_o, InstrPast_o;
    logic        busy_o, fetch_err_o, misalign_o;

    int vectors = 0;
    int fails   = 0;

    logic [31:0] req_q[$];
    resp_t       resp_q[$];

    instr_fetch_unit_if imem();

    instr_fetch_unit #(
        .RESET_PC       (32'h0000_0000),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .IRWrite_i   (IRWrite_i),
        .PCWrite_i   (PCWrite_i),
        .PCNext_i    (PCNext_i),
        .imem        (imem.master),
        .PC_o        (PC_o),
        .OldPC_o     (OldPC_o),
        .Instr_o     (Instr_o),
        .InstrPast_o (InstrPast_o),
        .busy_o      (busy_o),
        .fetch_err_o (fetch_err_o),
        .misalign_o  (misalign_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic pc_write(input logic [31:0] v);
        PCWrite_i = 1'b1;
        PCNext_i  = v;
        tick();
        PCWrite_i = 1'b0;
    endtask

    // rv_wait < 0 means no response: expect a timeout
    task automatic do_fetch(input logic [31:0] exp_addr, input int gnt_wait, input int rv_wait,
                            input logic [31:0] data, input logic pc_wr,
                            input logic [31:0] pc_next, input logic noise);
        int first;
        int pulses;
        req_q.push_back(exp_addr);
        IRWrite_i = 1'b1;
        PCWrite_i = pc_wr;
        PCNext_i  = pc_next;
        tick();
        IRWrite_i = 1'b0;
        PCWrite_i = 1'b0;
        for (int i = 0; i < gnt_wait; i++) begin
            if (noise && i == 0) IRWrite_i = 1'b1;
            if (noise && i == 1) begin
                imem.rvalid = 1'b1;
                imem.rdata  = 32'hBAD0_BAD0;
            end
            check("req_held", 32'(imem.req), 32'd1);
            check("addr_held", imem.addr, exp_addr);
            tick();
            IRWrite_i   = 1'b0;
            imem.rvalid = 1'b0;
            imem.rdata  = 32'hDEAD_BEEF;
        end
        check("req_at_gnt", 32'(imem.req), 32'd1);
        check("addr_at_gnt", imem.addr, exp_addr);
        imem.gnt = 1'b1;
        tick();
        imem.gnt = 1'b0;
        if (rv_wait >= 0) begin
            repeat (rv_wait) tick();
            imem.rvalid = 1'b1;
            imem.rdata  = data;
            tick();
            imem.rvalid = 1'b0;
            imem.rdata  = 32'hDEAD_BEEF;
        end else begin
            first  = 0;
            pulses = 0;
            for (int i = 1; i <= 6; i++) begin
                tick();
                if (fetch_err_o) begin
                    pulses++;
                    if (first == 0) first = i;
                end
            end
            check("err_cycle", 32'(first), 32'd4);
            check("err_pulses", 32'(pulses), 32'd1);
        end
        tick();
        tick();
        check("req_idle", 32'(imem.req), 32'd0);
        check("busy_idle", 32'(busy_o), 32'd0);
    endtask

    // Monitor: compares request addresses and completed fetches against the queues
    int   busy_cnt = 0;
    int   err_cnt  = 0;
    logic prev_busy = 1'b0;

    always @(negedge clk_i) begin
        logic [31:0] ea;
        resp_t       er;
        if (rst_i) begin
            busy_cnt  = 0;
            err_cnt   = 0;
            prev_busy = 1'b0;
        end else begin
            if (busy_o) busy_cnt++;
            if (fetch_err_o) err_cnt++;
            if (imem.req && imem.gnt) begin
                if (req_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL unexpected_req: addr %h, no request expected", imem.addr);
                end else begin
                    ea = req_q.pop_front();
                    check("req_addr", imem.addr, ea);
                end
            end
            if (prev_busy && !busy_o) begin
                if (resp_q.size() == 0) begin
                    vectors++;
                    fails++;
                    $display("FAIL unexpected_done: no completion expected");
                end else begin
                    er = resp_q.pop_front();
                    check("resp_err", 32'(err_cnt), 32'(er.err));
                    check("instr", Instr_o, er.instr);
                    check("instr_past", InstrPast_o, er.past);
                    check("old_pc", OldPC_o, er.oldpc);
                    check("busy_cycles", 32'(busy_cnt), 32'(er.busy));
                end
                busy_cnt = 0;
                err_cnt  = 0;
            end
            prev_busy = busy_o;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        imem.gnt    = 1'b0;
        imem.rvalid = 1'b0;
        imem.rdata  = 32'hDEAD_BEEF;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_pc", PC_o, 32'h0);
        check("rst_oldpc", OldPC_o, 32'h0);
        check("rst_instr", Instr_o, 32'h13);
        check("rst_past", InstrPast_o, 32'h13);
        check("rst_req", 32'(imem.req), 32'd0);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_err", 32'(fetch_err_o), 32'd0);
        check("rst_misalign", 32'(misalign_o), 32'd0);
        rst_i = 1'b0;
        tick();

        // zero-wait fetch
        pc_write(32'h100);
        check("pc_write", PC_o, 32'h100);
        resp_q.push_back('{1'b0, 32'h0050_0093, 32'h13, 32'h100, 2});
        do_fetch(32'h100, 0, 0, 32'h0050_0093, 1'b0, 32'h0, 1'b0);

        // back-pressure, with a stray IRWrite and rvalid during REQ
        pc_write(32'h104);
        resp_q.push_back('{1'b0, 32'h0020_81B3, 32'h0050_0093, 32'h104, 6});
        do_fetch(32'h104, 3, 1, 32'h0020_81B3, 1'b0, 32'h0, 1'b1);
        repeat (3) begin
            check("no_second_req", 32'(imem.req), 32'd0);
            tick();
        end

        // timeout
        pc_write(32'h108);
        resp_q.push_back('{1'b1, 32'h0020_81B3, 32'h0050_0093, 32'h104, 6});
        do_fetch(32'h108, 0, -1, 32'h0, 1'b0, 32'h0, 1'b0);
        check("instr_after_err", Instr_o, 32'h0020_81B3);

        // normal fetch after an error
        pc_write(32'h10C);
        resp_q.push_back('{1'b0, 32'h0000_0033, 32'h0020_81B3, 32'h10C, 2});
        do_fetch(32'h10C, 0, 0, 32'h0000_0033, 1'b0, 32'h0, 1'b0);

        // PCWrite on the same edge as IRWrite
        pc_write(32'h104);
        resp_q.push_back('{1'b0, 32'h0010_8113, 32'h0000_0033, 32'h104, 2});
        do_fetch(32'h104, 0, 0, 32'h0010_8113, 1'b1, 32'h200, 1'b0);
        check("pc_same_edge", PC_o, 32'h200);
        check("misalign_clear", 32'(misalign_o), 32'd0);

        // misaligned PC write
        pc_write(32'h202);
        check("misalign_set", 32'(misalign_o), 32'd1);
        check("pc_unaligned", PC_o, 32'h202);
        resp_q.push_back('{1'b0, 32'h0021_0193, 32'h0010_8113, 32'h200, 3});
        do_fetch(32'h200, 1, 0, 32'h0021_0193, 1'b0, 32'h0, 1'b0);
        pc_write(32'h300);
        check("misalign_sticky", 32'(misalign_o), 32'd1);
        check("pc_300", PC_o, 32'h300);

        // reset during RESP aborts; late rvalid ignored
        req_q.push_back(32'h300);
        IRWrite_i = 1'b1;
        tick();
        IRWrite_i = 1'b0;
        imem.gnt  = 1'b1;
        tick();
        imem.gnt = 1'b0;
        tick();
        #2 rst_i = 1'b1;
        #1;
        check("abort_req", 32'(imem.req), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_pc", PC_o, 32'h0);
        check("abort_instr", Instr_o, 32'h13);
        check("abort_past", InstrPast_o, 32'h13);
        check("abort_misalign", 32'(misalign_o), 32'd0);
        @(negedge clk_i);
        @(posedge clk_i);
        #1 rst_i = 1'b0;
        imem.rvalid = 1'b1;
        imem.rdata  = 32'h00A0_0093;
        tick();
        imem.rvalid = 1'b0;
        tick();
        check("late_rvalid_instr", Instr_o, 32'h13);
        check("late_rvalid_oldpc", OldPC_o, 32'h0);
        check("late_rvalid_busy", 32'(busy_o), 32'd0);
        repeat (2) tick();

        check("req_q_drained", 32'(req_q.size()), 32'd0);
        check("resp_q_drained", 32'(resp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
